// File: rtl/inst_sram_resp.sv
// Instruction SRAM responder. It clears itself after reset, then serves CPU
// reads and byte-lane writes and accepts full-word preloads from a side port.
module inst_sram_resp #(
  parameter int unsigned ADDR_W = 10,
  parameter logic [31:0] BASE   = 32'hbfc0_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_sram_en,
  input  logic [3:0]        inst_sram_wen,
  input  logic [31:0]       inst_sram_addr,
  input  logic [31:0]       inst_sram_wdata,
  output logic [31:0]       inst_sram_rdata,
  output logic              addr_err,
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic              load_ready,
  output logic              ready
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;
  logic              clr_we;

  logic [31:0]       mem [DEPTH];

  logic [ADDR_W-1:0] index;
  logic              in_range;
  logic              is_read;
  logic              is_write;
  logic              unused_addr_lsb;

  // Request decode; the byte offset within a word plays no part.
  assign index           = inst_sram_addr[ADDR_W+1:2];
  assign in_range        = (inst_sram_addr[31:ADDR_W+2] == BASE[31:ADDR_W+2]);
  assign is_read         = inst_sram_en && (inst_sram_wen == 4'h0);
  assign is_write        = inst_sram_en && (inst_sram_wen != 4'h0);
  assign unused_addr_lsb = ^inst_sram_addr[1:0];

  assign ready      = (state == RUN);
  assign load_ready = (state == RUN) && !is_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Clear walks every word once, then hands over to normal operation.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_we    = 1'b0;
    case (state)
      CLEAR: begin
        clr_we  = 1'b1;
        cnt_nxt = cnt + ADDR_W'(1);
        if (cnt == '1) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        state_nxt = RUN;
      end
      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

  // Storage; CPU writes and preloads are mutually exclusive via load_ready.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clr_we) begin
        mem[cnt] <= 32'h0;
      end else if (state == RUN) begin
        if (is_write && in_range) begin
          for (int i = 0; i < 4; i++) begin
            if (inst_sram_wen[i]) begin
              mem[index][8*i +: 8] <= inst_sram_wdata[8*i +: 8];
            end
          end
        end
        if (load_valid && load_ready) begin
          mem[load_addr] <= load_data;
        end
      end
    end
  end

  // Read port samples the array before this cycle's writes land (read-first).
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_sram_rdata <= 32'h0;
      addr_err        <= 1'b0;
    end else begin
      addr_err <= 1'b0;
      if (is_read) begin
        if ((state == RUN) && in_range) begin
          inst_sram_rdata <= mem[index];
        end else begin
          inst_sram_rdata <= 32'h0;
        end
        addr_err <= (state == RUN) && !in_range;
      end
    end
  end

endmodule

// File: tb/tb_inst_sram_resp.sv
// Directed bench for inst_sram_resp: clear timing, preload, byte writes,
// range errors, read-first collisions and reset during clear.
module tb_inst_sram_resp;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  logic              clk;
  logic              reset;
  logic              inst_sram_en;
  logic [3:0]        inst_sram_wen;
  logic [31:0]       inst_sram_addr;
  logic [31:0]       inst_sram_wdata;
  logic [31:0]       inst_sram_rdata;
  logic              addr_err;
  logic              load_valid;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;
  logic              load_ready;
  logic              ready;

  int total;
  int bad;

  inst_sram_resp #(.ADDR_W(ADDR_W), .BASE(32'hbfc0_0000)) dut (
    .clk             (clk),
    .reset           (reset),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .addr_err        (addr_err),
    .load_valid      (load_valid),
    .load_addr       (load_addr),
    .load_data       (load_data),
    .load_ready      (load_ready),
    .ready           (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_sram_en    = 1'b0;
    inst_sram_wen   = 4'h0;
    inst_sram_addr  = 32'h0;
    inst_sram_wdata = 32'h0;
    load_valid      = 1'b0;
    load_addr       = '0;
    load_data       = 32'h0;
  endtask

  task automatic cpu_read(input logic [31:0] a);
    idle();
    inst_sram_en   = 1'b1;
    inst_sram_addr = a;
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    idle();
    inst_sram_en    = 1'b1;
    inst_sram_wen   = w;
    inst_sram_addr  = a;
    inst_sram_wdata = d;
  endtask

  // Counts cycles until ready rises, bounded; also notes any nonzero rdata.
  task automatic wait_ready(output int cyc, output logic rd_nz);
    cyc   = 0;
    rd_nz = 1'b0;
    while (!ready && cyc < 2 * DEPTH) begin
      tick();
      cyc++;
      if (inst_sram_rdata != 32'h0) rd_nz = 1'b1;
    end
  endtask

  task automatic do_load(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    idle();
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    tick();
    idle();
  endtask

  int   cyc;
  logic nz;

  initial begin
    total = 0;
    bad   = 0;
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_rdata", inst_sram_rdata, 32'h0);
    chk("rst_addr_err", 32'(addr_err), 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_load_ready", 32'(load_ready), 32'h0);

    // Clear must take exactly DEPTH cycles.
    wait_ready(cyc, nz);
    chk("clear_cycles", 32'(cyc), 32'(DEPTH));
    chk("clear_rdata_zero", 32'(nz), 32'h0);

    // Preload then read word 0.
    idle();
    load_valid = 1'b1;
    load_addr  = '0;
    load_data  = 32'h3c08_bfaf;
    #1;
    chk("load_ready_idle", 32'(load_ready), 32'h1);
    tick();
    cpu_read(32'hbfc0_0000);
    tick();
    chk("preload_read", inst_sram_rdata, 32'h3c08_bfaf);
    chk("preload_read_err", 32'(addr_err), 32'h0);

    // Preload idx1 concurrent with a read of idx1 returns the old word.
    cpu_read(32'hbfc0_0004);
    load_valid = 1'b1;
    load_addr  = ADDR_W'(1);
    load_data  = 32'h5;
    tick();
    chk("read_first_old", inst_sram_rdata, 32'h0);
    cpu_read(32'hbfc0_0004);
    tick();
    chk("read_first_new", inst_sram_rdata, 32'h5);

    // Byte-lane write merge, with a blocked concurrent preload.
    do_load(ADDR_W'(1), 32'h1122_3344);
    cpu_read(32'hbfc0_0000);
    tick();
    cpu_write(32'hbfc0_0004, 4'b0101, 32'haabb_ccdd);
    load_valid = 1'b1;
    load_addr  = ADDR_W'(5);
    load_data  = 32'hdead_beef;
    #1;
    chk("load_ready_cpu_write", 32'(load_ready), 32'h0);
    tick();
    chk("write_rdata_hold", inst_sram_rdata, 32'h3c08_bfaf);
    cpu_read(32'hbfc0_0004);
    tick();
    chk("byte_merge", inst_sram_rdata, 32'h11bb_33dd);
    cpu_read(32'hbfc0_0014);
    tick();
    chk("blocked_load_dropped", inst_sram_rdata, 32'h0);

    // Out-of-range read pulses addr_err once; idle holds rdata.
    cpu_read(32'h8000_0000);
    tick();
    chk("oor_rdata", inst_sram_rdata, 32'h0);
    chk("oor_err", 32'(addr_err), 32'h1);
    idle();
    tick();
    chk("idle_rdata_hold", inst_sram_rdata, 32'h0);
    chk("idle_err_clear", 32'(addr_err), 32'h0);

    // Out-of-range write is silently dropped.
    cpu_write(32'h8000_0004, 4'hf, 32'hffff_ffff);
    tick();
    chk("oor_write_no_err", 32'(addr_err), 32'h0);

    // Back-to-back reads, one result per cycle.
    cpu_read(32'hbfc0_0004);
    tick();
    chk("b2b_0", inst_sram_rdata, 32'h11bb_33dd);
    cpu_read(32'hbfc0_0000);
    tick();
    chk("b2b_1", inst_sram_rdata, 32'h3c08_bfaf);
    cpu_read(32'hbfc0_0007);
    tick();
    chk("b2b_2", inst_sram_rdata, 32'h11bb_33dd);
    idle();

    // Reset in mid-run, then again at clear counter 5.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    cpu_write(32'hbfc0_0000, 4'hf, 32'hcafe_f00d);
    tick();
    reset = 1'b0;
    chk("rerst_ready", 32'(ready), 32'h0);
    cpu_write(32'hbfc0_0008, 4'hf, 32'h1234_5678);
    tick();
    cpu_read(32'h8000_0000);
    tick();
    chk("clear_oor_no_err", 32'(addr_err), 32'h0);
    cpu_read(32'hbfc0_0004);
    tick();
    chk("clear_read_zero", inst_sram_rdata, 32'h0);
    idle();
    wait_ready(cyc, nz);
    chk("reclear_cycles", 32'(cyc + 3), 32'(DEPTH));
    cpu_read(32'hbfc0_0000);
    tick();
    chk("reclear_w0", inst_sram_rdata, 32'h0);
    cpu_read(32'hbfc0_0004);
    tick();
    chk("reclear_w1", inst_sram_rdata, 32'h0);
    cpu_read(32'hbfc0_0008);
    tick();
    chk("reclear_w2", inst_sram_rdata, 32'h0);
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_sram_resp.md
INST_SRAM_RESP -- requirements
Module: inst_sram_resp

Interface
REQ-001 SHALL have parameter ADDR_W, 10, word-index width; storage depth is 2^ADDR_W 32-bit words.
REQ-002 SHALL have parameter BASE, 32'hbfc0_0000, byte address mapped to word 0.
REQ-003 clk  in  1  clock; all state updates on posedge clk.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 inst_sram_en  in  1  request valid; one request per asserted cycle.
REQ-006 inst_sram_wen  in  4  byte write enables; 4'h0 means read.
REQ-007 inst_sram_addr  in  32  byte address of the request.
REQ-008 inst_sram_wdata  in  32  write data, byte lane i = bits 8i+7:8i.
REQ-009 inst_sram_rdata  out  32  read data, registered, valid the cycle after a read request.
REQ-010 addr_err  out  1  one-cycle pulse, aligned with rdata, for an out-of-range read.
REQ-011 load_valid  in  1  preload word offered.
REQ-012 load_addr  in  ADDR_W  preload word index.
REQ-013 load_data  in  32  preload word.
REQ-014 load_ready  out  1  preload accepted this cycle when load_valid is also high.
REQ-015 ready  out  1  high once the post-reset clear has finished.

Function
REQ-016 SHALL decode index = inst_sram_addr[ADDR_W+1:2] and in_range = (inst_sram_addr[31:ADDR_W+2] == BASE[31:ADDR_W+2]); addr[1:0] are ignored.
REQ-017 SHALL implement a two-state FSM: CLEAR and RUN; reset enters CLEAR with clear counter = 0.
REQ-018 In CLEAR SHALL write 32'h0 to mem[counter] each cycle and increment counter; at counter == 2^ADDR_W-1 SHALL write that word and go to RUN next cycle.
REQ-019 ready SHALL be 0 in CLEAR and 1 in RUN; first ready=1 cycle is the cycle after the last clear write (clear takes exactly 2^ADDR_W cycles).
REQ-020 In CLEAR, a request SHALL be ignored for writes; a read SHALL return 32'h0 next cycle with addr_err = 0.
REQ-021 In RUN, read (en=1, wen=0): next cycle rdata = mem[index] if in_range, else rdata = 32'h0 and addr_err = 1.
REQ-022 In RUN, write (en=1, wen!=0): SHALL update only byte lanes with wen[i]=1 at mem[index] when in_range; out-of-range writes SHALL be dropped silently (no addr_err); rdata SHALL hold.
REQ-023 When en=0, rdata SHALL hold its previous value; addr_err SHALL be 0.
REQ-024 load_ready SHALL equal (state==RUN) && !(inst_sram_en && wen!=0); an accepted preload SHALL write all 32 bits of mem[load_addr].
REQ-025 Simultaneous preload write and CPU read to the same index: read SHALL return the old (pre-write) word (read-first).
REQ-026 Back-to-back reads on consecutive cycles SHALL each return data one cycle later, full throughput, no bubbles.
REQ-027 A CPU write followed next cycle by a read of the same index SHALL return the merged new word.

Reset
REQ-028 On reset: state=CLEAR, counter=0, rdata=32'h0, addr_err=0, ready=0, load_ready=0.
REQ-029 Reset asserted mid-clear or mid-run SHALL restart the clear from index 0 on the next cycle; memory contents SHALL end all-zero after the clear.
REQ-030 A request presented in the same cycle reset is high SHALL have no effect.

Verification
REQ-031 Reset, hold en=0 for 2^ADDR_W cycles -> ready rises exactly at cycle 2^ADDR_W after reset release; rdata=0 throughout.
REQ-032 After ready, preload idx 0 = 32'h3c08_bfaf, read addr 32'hbfc0_0000 -> rdata 32'h3c08_bfaf next cycle, addr_err=0.
REQ-033 Write wen=4'b0101, wdata=32'haabb_ccdd to 32'hbfc0_0004 over word 32'h1122_3344, read next cycle -> 32'h11bb_33dd.
REQ-034 Read 32'h8000_0000 -> rdata 32'h0, addr_err pulses 1 for one cycle; then en=0 -> rdata holds 32'h0, addr_err=0.
REQ-035 Preload idx 1 = 32'h5 while CPU reads 32'hbfc0_0004 (old 32'h0) same cycle -> rdata 32'h0; re-read -> 32'h5; CPU write concurrent with load_valid -> load_ready=0.
REQ-036 Reset pulsed at clear counter = 5 -> ready stays 0 for a further full 2^ADDR_W cycles; preloaded words read back 32'h0.
